rc5_job_scheduler: RTL and testbench

- Sequences the RC5 datapath (key expander, cipher, decipher) for one host request stream.
- Accepts encrypt/decrypt jobs over a valid/ready handshake and triggers key expansion only when the key RAM has changed since the last expansion.
- Grants the shared S-table to exactly one engine at a time and returns results over a second valid/ready handshake.
- Sits between the host interface and the RC5 top level, replacing direct host drive of iStartCipher/iStartDecipher.

---
 rtl/rc5_job_scheduler.sv | 232 +++++++++++++++++++++++
 tb/tb_rc5_job_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rc5_job_scheduler.sv
// Job sequencer for the RC5 datapath: accepts host jobs, expands the key only when the key RAM
// changed, grants the S-table to one engine at a time and returns results to the host.
module rc5_job_scheduler #(
  parameter int unsigned W       = 32,
  parameter int unsigned SETTLE  = 2,
  parameter int unsigned TIMEOUT = 1023,
  parameter int unsigned TO_BITS = $clog2(TIMEOUT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         iReqValid,
  output logic         oReqReady,
  input  logic         iReqDecrypt,
  input  logic [W-1:0] iReqA,
  input  logic [W-1:0] iReqB,
  input  logic         iKeyWen,
  output logic         oExpandStart,
  input  logic         iKeyExpanderDone,
  output logic         oStartCipher,
  output logic         oStartDecipher,
  output logic [W-1:0] oA,
  output logic [W-1:0] oB,
  input  logic         iDoneCipher,
  input  logic         iDoneDecipher,
  input  logic [W-1:0] iCipherA,
  input  logic [W-1:0] iCipherB,
  input  logic [W-1:0] iDecipherA,
  input  logic [W-1:0] iDecipherB,
  output logic         oRspValid,
  input  logic         iRspReady,
  output logic [W-1:0] oRspA,
  output logic [W-1:0] oRspB,
  output logic         oRspDecrypt,
  output logic         oRspError,
  output logic         oBusy
);

  localparam logic [2:0] StIdle   = 3'd0;
  localparam logic [2:0] StExpand = 3'd1;
  localparam logic [2:0] StSettle = 3'd2;
  localparam logic [2:0] StRun    = 3'd3;
  localparam logic [2:0] StResp   = 3'd4;

  localparam int unsigned SettleBits = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SettleBits-1:0] SettleLast = SettleBits'((SETTLE > 0) ? SETTLE - 1 : 0);
  localparam logic [TO_BITS-1:0] TimeoutLast = TO_BITS'(TIMEOUT - 1);

  logic [2:0]            state_q, state_d;
  logic                  job_dec_q, job_dec_d;
  logic [W-1:0]          op_a_q, op_a_d;
  logic [W-1:0]          op_b_q, op_b_d;
  logic [W-1:0]          rsp_a_q, rsp_a_d;
  logic [W-1:0]          rsp_b_q, rsp_b_d;
  logic                  rsp_err_q, rsp_err_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [TO_BITS-1:0]    to_cnt_q, to_cnt_d;
  logic [SettleBits-1:0] settle_cnt_q, settle_cnt_d;
  logic                  key_valid_q, key_valid_d;
  logic                  key_wr_q, key_wr_d;
  logic                  expanded_q, expanded_d;
  logic                  req_ready_q, req_ready_d;
  logic                  expand_start_q, expand_start_d;
  logic                  start_ci_q, start_ci_d;
  logic                  start_de_q, start_de_d;
  logic                  busy_q, busy_d;
  logic                  eng_done;

  always_comb begin
    state_d      = state_q;
    job_dec_d    = job_dec_q;
    op_a_d       = op_a_q;
    op_b_d       = op_b_q;
    rsp_a_d      = rsp_a_q;
    rsp_b_d      = rsp_b_q;
    rsp_err_d    = rsp_err_q;
    to_cnt_d     = to_cnt_q;
    settle_cnt_d = settle_cnt_q;
    expanded_d   = expanded_q;
    key_valid_d  = key_valid_q;
    // Remembers a key write since the job started so an expansion that raced it is not trusted.
    key_wr_d     = key_wr_q | iKeyWen;
    eng_done     = job_dec_q ? iDoneDecipher : iDoneCipher;

    unique case (state_q)
      StIdle: begin
        if (iReqValid && req_ready_q) begin
          job_dec_d  = iReqDecrypt;
          op_a_d     = iReqA;
          op_b_d     = iReqB;
          key_wr_d   = 1'b0;
          expanded_d = 1'b0;
          if (key_valid_q && !iKeyWen) begin
            if (SETTLE == 0) begin
              state_d  = StRun;
              to_cnt_d = '0;
            end else begin
              state_d      = StSettle;
              settle_cnt_d = '0;
            end
          end else begin
            state_d  = StExpand;
            to_cnt_d = '0;
          end
        end
      end

      StExpand: begin
        to_cnt_d = to_cnt_q + TO_BITS'(1);
        if (iKeyExpanderDone) begin
          key_valid_d = !(key_wr_q || iKeyWen);
          expanded_d  = 1'b1;
          if (SETTLE == 0) begin
            state_d  = StRun;
            to_cnt_d = '0;
          end else begin
            state_d      = StSettle;
            settle_cnt_d = '0;
          end
        end else if (to_cnt_q == TimeoutLast) begin
          state_d   = StResp;
          rsp_a_d   = '0;
          rsp_b_d   = '0;
          rsp_err_d = 1'b1;
        end
      end

      StSettle: begin
        if (settle_cnt_q == SettleLast) begin
          state_d  = StRun;
          to_cnt_d = '0;
        end else begin
          settle_cnt_d = settle_cnt_q + SettleBits'(1);
        end
      end

      StRun: begin
        to_cnt_d = to_cnt_q + TO_BITS'(1);
        if (eng_done) begin
          state_d   = StResp;
          rsp_a_d   = job_dec_q ? iDecipherA : iCipherA;
          rsp_b_d   = job_dec_q ? iDecipherB : iCipherB;
          rsp_err_d = 1'b0;
        end else if (to_cnt_q == TimeoutLast) begin
          state_d   = StResp;
          rsp_a_d   = '0;
          rsp_b_d   = '0;
          rsp_err_d = 1'b1;
        end
      end

      StResp: begin
        if (iRspReady) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase

    if (iKeyWen) begin
      key_valid_d = 1'b0;
    end

    // Outputs are registered copies of what the next state implies.
    req_ready_d    = (state_d == StIdle);
    busy_d         = (state_d != StIdle);
    rsp_valid_d    = (state_d == StResp);
    expand_start_d = (state_d == StExpand) || ((state_d == StSettle) && expanded_d);
    start_ci_d     = (state_d == StRun) && !job_dec_d;
    start_de_d     = (state_d == StRun) && job_dec_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      job_dec_q      <= 1'b0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      rsp_a_q        <= '0;
      rsp_b_q        <= '0;
      rsp_err_q      <= 1'b0;
      rsp_valid_q    <= 1'b0;
      to_cnt_q       <= '0;
      settle_cnt_q   <= '0;
      key_valid_q    <= 1'b0;
      key_wr_q       <= 1'b0;
      expanded_q     <= 1'b0;
      req_ready_q    <= 1'b1;
      expand_start_q <= 1'b0;
      start_ci_q     <= 1'b0;
      start_de_q     <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      job_dec_q      <= job_dec_d;
      op_a_q         <= op_a_d;
      op_b_q         <= op_b_d;
      rsp_a_q        <= rsp_a_d;
      rsp_b_q        <= rsp_b_d;
      rsp_err_q      <= rsp_err_d;
      rsp_valid_q    <= rsp_valid_d;
      to_cnt_q       <= to_cnt_d;
      settle_cnt_q   <= settle_cnt_d;
      key_valid_q    <= key_valid_d;
      key_wr_q       <= key_wr_d;
      expanded_q     <= expanded_d;
      req_ready_q    <= req_ready_d;
      expand_start_q <= expand_start_d;
      start_ci_q     <= start_ci_d;
      start_de_q     <= start_de_d;
      busy_q         <= busy_d;
    end
  end

  assign oReqReady      = req_ready_q;
  assign oExpandStart   = expand_start_q;
  assign oStartCipher   = start_ci_q;
  assign oStartDecipher = start_de_q;
  assign oA             = op_a_q;
  assign oB             = op_b_q;
  assign oRspValid      = rsp_valid_q;
  assign oRspA          = rsp_a_q;
  assign oRspB          = rsp_b_q;
  assign oRspDecrypt    = job_dec_q;
  assign oRspError      = rsp_err_q;
  assign oBusy          = busy_q;

  // Only one agent may own the S-table port at a time.
  mutex_starts: assert property (@(posedge clk) disable iff (rst)
    $onehot0({expand_start_q, start_ci_q, start_de_q}));

endmodule

// File: tb/tb_rc5_job_scheduler.sv
// Randomized bench for rc5_job_scheduler: stub expander/engines with chosen latencies and a
// job-level reference model of key caching, latency, timeouts and response contents.
module tb_rc5_job_scheduler;

  localparam int unsigned W = 32;
  localparam int Settle  = 2;
  localparam int Timeout = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         iReqValid, oReqReady, iReqDecrypt;
  logic [W-1:0] iReqA, iReqB;
  logic         iKeyWen, oExpandStart, iKeyExpanderDone, oStartCipher, oStartDecipher;
  logic [W-1:0] oA, oB;
  logic         iDoneCipher, iDoneDecipher;
  logic [W-1:0] iCipherA, iCipherB, iDecipherA, iDecipherB;
  logic         oRspValid, iRspReady, oRspDecrypt, oRspError, oBusy;
  logic [W-1:0] oRspA, oRspB;

  always #5 clk = ~clk;

  rc5_job_scheduler #(
    .W       (W),
    .SETTLE  (Settle),
    .TIMEOUT (Timeout)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .iReqValid        (iReqValid),
    .oReqReady        (oReqReady),
    .iReqDecrypt      (iReqDecrypt),
    .iReqA            (iReqA),
    .iReqB            (iReqB),
    .iKeyWen          (iKeyWen),
    .oExpandStart     (oExpandStart),
    .iKeyExpanderDone (iKeyExpanderDone),
    .oStartCipher     (oStartCipher),
    .oStartDecipher   (oStartDecipher),
    .oA               (oA),
    .oB               (oB),
    .iDoneCipher      (iDoneCipher),
    .iDoneDecipher    (iDoneDecipher),
    .iCipherA         (iCipherA),
    .iCipherB         (iCipherB),
    .iDecipherA       (iDecipherA),
    .iDecipherB       (iDecipherB),
    .oRspValid        (oRspValid),
    .iRspReady        (iRspReady),
    .oRspA            (oRspA),
    .oRspB            (oRspB),
    .oRspDecrypt      (oRspDecrypt),
    .oRspError        (oRspError),
    .oBusy            (oBusy)
  );

  // Stub expander and engines: done after a programmed number of start-high cycles.
  int           exp_lat = 0, eng_lat = 0, exp_cnt = 0, run_cnt = 0;
  bit           exp_hang = 1'b0, eng_hang = 1'b0;
  logic         spur_c = 1'b0, spur_d = 1'b0;
  logic [W-1:0] c_a = '0, c_b = '0, d_a = '0, d_b = '0;

  always @(posedge clk) begin
    exp_cnt <= oExpandStart ? exp_cnt + 1 : 0;
    run_cnt <= (oStartCipher || oStartDecipher) ? run_cnt + 1 : 0;
    spur_c  <= 1'($urandom_range(0, 1));
    spur_d  <= 1'($urandom_range(0, 1));
  end

  assign iKeyExpanderDone = oExpandStart && !exp_hang && (exp_cnt >= exp_lat);
  assign iDoneCipher      = oStartCipher ? (!eng_hang && run_cnt == eng_lat) : spur_c;
  assign iDoneDecipher    = oStartDecipher ? (!eng_hang && run_cnt == eng_lat) : spur_d;
  assign iCipherA   = c_a;
  assign iCipherB   = c_b;
  assign iDecipherA = d_a;
  assign iDecipherB = d_b;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Per-cycle observation, sampled on the falling edge.
  int           cyc = 0, n_exp = 0, n_ci = 0, n_de = 0, n_mutex = 0;
  bit           op_seen = 1'b0;
  logic [W-1:0] op_a_seen = '0, op_b_seen = '0;

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (oExpandStart) n_exp++;
    if (oStartCipher) n_ci++;
    if (oStartDecipher) n_de++;
    if (int'(oExpandStart) + int'(oStartCipher) + int'(oStartDecipher) > 1) n_mutex++;
    if ((oStartCipher || oStartDecipher) && !op_seen) begin
      op_seen   = 1'b1;
      op_a_seen = oA;
      op_b_seen = oB;
    end
  endtask

  // Current job description and reference model state.
  logic         j_dec;
  logic [W-1:0] j_a, j_b, j_ca, j_cb, j_da, j_db;
  int           j_x, j_e, j_kw, j_bp;
  bit           j_xhang, j_ehang, j_early;
  bit           allow_early = 1'b1;
  bit           kv_m = 1'b0;

  task automatic gen_job(input bit allow_pre_kw);
    int r;
    j_dec   = 1'($urandom_range(0, 1));
    j_a     = $urandom;
    j_b     = $urandom;
    j_ca    = $urandom;
    j_cb    = $urandom;
    j_da    = $urandom;
    j_db    = $urandom;
    j_x     = $urandom_range(0, 6);
    j_e     = $urandom_range(0, 10);
    j_xhang = ($urandom_range(0, 9) == 0);
    j_ehang = ($urandom_range(0, 9) == 0);
    r       = $urandom_range(0, 5);
    j_kw    = (r > 3) ? 0 : r;
    if (!allow_pre_kw && j_kw == 1) j_kw = 0;
    j_bp    = $urandom_range(0, 10);
    j_early = allow_early && ($urandom_range(0, 1) == 1);
  endtask

  task automatic present_job();
    exp_lat     = j_x;
    eng_lat     = j_e;
    exp_hang    = j_xhang;
    eng_hang    = j_ehang;
    c_a         = j_ca;
    c_b         = j_cb;
    d_a         = j_da;
    d_b         = j_db;
    iReqDecrypt = j_dec;
    iReqA       = j_a;
    iReqB       = j_b;
    iReqValid   = 1'b1;
  endtask

  task automatic run_job(input bit presented, output bit early_out);
    int           waited, acc, lat, lat_exp, exp_n, sel_n;
    bit           do_exp, xto, eto, err, kw_hit, stable_ok, ready_ok;
    logic [W-1:0] ea, eb, a_in, b_in;
    logic         e_dec;
    if (!presented) begin
      if (j_kw == 1) begin
        iKeyWen = 1'b1;
        tick();
        iKeyWen = 1'b0;
        kv_m    = 1'b0;
      end
      present_job();
    end
    n_exp = 0; n_ci = 0; n_de = 0; n_mutex = 0; op_seen = 1'b0;
    waited = 0;
    while (!oReqReady && waited < 40) begin
      tick();
      waited++;
    end
    check("req_ready", 32'(oReqReady), 32'd1);
    if (presented) check("accept_after_handshake", 32'(waited), 32'd0);
    acc    = cyc;
    do_exp = !kv_m;
    a_in   = j_a;
    b_in   = j_b;
    tick();
    iReqValid = 1'b0;
    check("busy", 32'(oBusy), 32'd1);
    kw_hit = 1'b0;
    waited = 0;
    while (!oRspValid && waited < 200) begin
      iKeyWen = 1'b0;
      if (!kw_hit && ((j_kw == 2 && (oStartCipher || oStartDecipher)) ||
                      (j_kw == 3 && oExpandStart))) begin
        iKeyWen = 1'b1;
        kw_hit  = 1'b1;
      end
      tick();
      waited++;
    end
    iKeyWen = 1'b0;
    lat     = cyc - acc;

    xto     = do_exp && j_xhang;
    eto     = !xto && j_ehang;
    err     = xto || eto;
    exp_n   = do_exp ? (xto ? Timeout : j_x + 1 + Settle) : 0;
    sel_n   = xto ? 0 : (eto ? Timeout : j_e + 1);
    lat_exp = 1 + (do_exp ? (xto ? Timeout : j_x + 1) : 0) + (xto ? 0 : Settle + sel_n);
    ea      = err ? '0 : (j_dec ? j_da : j_ca);
    eb      = err ? '0 : (j_dec ? j_db : j_cb);
    e_dec   = j_dec;

    check("rsp_valid", 32'(oRspValid), 32'd1);
    check("latency", 32'(lat), 32'(lat_exp));
    check("rsp_a", oRspA, ea);
    check("rsp_b", oRspB, eb);
    check("rsp_decrypt", 32'(oRspDecrypt), 32'(e_dec));
    check("rsp_error", 32'(oRspError), 32'(err));
    check("expand_cycles", 32'(n_exp), 32'(exp_n));
    check("sel_start_cycles", 32'(j_dec ? n_de : n_ci), 32'(sel_n));
    check("other_start_cycles", 32'(j_dec ? n_ci : n_de), 32'd0);
    check("start_mutex", 32'(n_mutex), 32'd0);
    if (sel_n > 0) begin
      check("op_a", op_a_seen, a_in);
      check("op_b", op_b_seen, b_in);
    end
    kv_m = kw_hit ? 1'b0 : (do_exp ? !xto : kv_m);

    stable_ok = 1'b1;
    ready_ok  = 1'b1;
    early_out = j_early && (j_bp > 0);
    for (int i = 0; i < j_bp; i++) begin
      if (i == 0 && early_out) begin
        gen_job(1'b0);
        present_job();
      end
      tick();
      if (oRspA !== ea || oRspB !== eb || oRspValid !== 1'b1 || oRspError !== err) begin
        stable_ok = 1'b0;
      end
      if (oReqReady !== 1'b0 || oBusy !== 1'b1) ready_ok = 1'b0;
    end
    iRspReady = 1'b1;
    tick();
    iRspReady = 1'b0;
    check("bp_stable", 32'(stable_ok), 32'd1);
    check("bp_ready_low", 32'(ready_ok), 32'd1);
    check("post_hs_valid", 32'(oRspValid), 32'd0);
    check("post_hs_ready", 32'(oReqReady), 32'd1);
    check("post_hs_busy", 32'(oBusy), 32'd0);
  endtask

  task automatic check_after_reset(input string tag);
    check({tag, "_starts"}, 32'({oExpandStart, oStartCipher, oStartDecipher}), 32'd0);
    check({tag, "_valid"}, 32'(oRspValid), 32'd0);
    check({tag, "_ready"}, 32'(oReqReady), 32'd1);
    check({tag, "_busy"}, 32'(oBusy), 32'd0);
  endtask

  initial begin
    bit early;
    int w;
    rst = 1'b1; iReqValid = 1'b0; iReqDecrypt = 1'b0; iReqA = '0; iReqB = '0;
    iKeyWen = 1'b0; iRspReady = 1'b0;
    repeat (3) @(posedge clk);
    tick();
    check_after_reset("reset");
    check("reset_rsp_a", oRspA, 32'd0);
    check("reset_rsp_err", 32'(oRspError), 32'd0);
    check("reset_op_a", oA, 32'd0);
    rst = 1'b0;
    tick();

    // Key load then cipher of zeros with an all-zero key.
    gen_job(1'b1);
    j_dec = 1'b0; j_a = '0; j_b = '0; j_ca = 32'hEEDBA521; j_cb = 32'h6D8F4B15;
    j_x = 4; j_e = 8; j_xhang = 1'b0; j_ehang = 1'b0; j_kw = 1; j_bp = 0; j_early = 1'b0;
    run_job(1'b0, early);
    // Decrypt of that result with the cached key.
    gen_job(1'b1);
    j_dec = 1'b1; j_a = 32'hEEDBA521; j_b = 32'h6D8F4B15; j_da = '0; j_db = '0;
    j_e = 8; j_xhang = 1'b0; j_ehang = 1'b0; j_kw = 0; j_bp = 10; j_early = 1'b0;
    run_job(1'b0, early);
    // Engine never finishes.
    gen_job(1'b1);
    j_dec = 1'b0; j_ehang = 1'b1; j_kw = 0; j_early = 1'b0;
    run_job(1'b0, early);
    // Key write, then the expander never finishes.
    gen_job(1'b1);
    j_xhang = 1'b1; j_kw = 1; j_early = 1'b0;
    run_job(1'b0, early);

    early = 1'b0;
    for (int n = 0; n < 40; n++) begin
      allow_early = (n < 39);
      if (!early) gen_job(1'b1);
      run_job(early, early);
    end

    // Synchronous reset while an engine is running.
    gen_job(1'b1);
    j_xhang = 1'b0; j_ehang = 1'b0; j_e = 10;
    present_job();
    tick();
    iReqValid = 1'b0;
    w = 0;
    while (!(oStartCipher || oStartDecipher) && w < 100) begin
      tick();
      w++;
    end
    check("reached_run", 32'(oStartCipher || oStartDecipher), 32'd1);
    rst = 1'b1;
    tick();
    check_after_reset("rst_run");
    rst = 1'b0;
    kv_m = 1'b0;
    tick();

    // Synchronous reset while a response is pending.
    gen_job(1'b1);
    j_xhang = 1'b0; j_ehang = 1'b0;
    present_job();
    tick();
    iReqValid = 1'b0;
    w = 0;
    while (!oRspValid && w < 100) begin
      tick();
      w++;
    end
    check("reached_resp", 32'(oRspValid), 32'd1);
    rst = 1'b1;
    tick();
    check_after_reset("rst_resp");
    rst = 1'b0;
    kv_m = 1'b0;
    tick();

    // Key must be re-expanded after reset.
    gen_job(1'b0);
    j_xhang = 1'b0; j_ehang = 1'b0; j_kw = 0;
    run_job(1'b0, early);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
